// File: rtl/demux_stream_n.sv
// demux_stream_n: registered 1-to-NUM_CH stream demultiplexer with packet-locked
// routing, a one-entry output register and illegal-select drop accounting.
module demux_stream_n #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err_sel,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
    logic [NUM_CH-1:0]  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               err_sel_q, err_sel_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               sel_bad;
    logic               discard;
    logic               full;
    logic               drain;
    logic               accept;
    logic [SEL_W-1:0]   dest_ch;

    // Handshake decode: discarded beats are always accepted, routed beats need room.
    always_comb begin
        sel_bad  = (32'(sel) >= NUM_CH);
        discard  = (state_q == ST_DROP) || ((state_q == ST_IDLE) && sel_bad);
        full     = |out_valid_q;
        drain    = |(out_valid_q & out_ready);
        in_ready = discard ? 1'b1 : (!full || drain);
        accept   = in_valid && in_ready;
        dest_ch  = (state_q == ST_IDLE) ? sel : lock_ch_q;
    end

    // Next-state, output register and drop counter update.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_sel_d   = 1'b0;
        drop_cnt_d  = drop_cnt_q;

        // A drain empties the register; a same-cycle load overrides below.
        if (drain) begin
            out_valid_d = '0;
        end

        if (accept) begin
            if (discard) begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    out_valid_d[i] = (32'(dest_ch) == i);
                end
                out_data_d = in_data;
                out_last_d = in_last;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sel_bad) begin
                        err_sel_d = 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end else begin
                        lock_ch_d = sel;
                        if (!in_last) state_d = ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (in_last) state_d = ST_IDLE;
                end
                ST_DROP: begin
                    if (in_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_sel_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_sel_q   <= err_sel_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err_sel   = err_sel_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Scoreboard bench for demux_stream_n with NUM_CH=6, DATA_W=8.
module tb_demux_stream_n;

    localparam int unsigned NCH = 6;
    localparam int unsigned DW  = 8;
    localparam int unsigned SW  = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [SW-1:0] sel;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_sel;
    logic [15:0]   drop_cnt;

    demux_stream_n #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_sel   (err_sel),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        int unsigned   ch;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t        sb_q[$];
    bit          err_at[int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    // Reference model of packet routing.
    bit          in_pkt  = 0;
    bit          drop_m  = 0;
    int unsigned lock_m  = 0;
    logic [15:0] exp_drop = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: err_sel timing, one-hot valid and in-order scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            check("err_sel", 32'(err_sel), 32'(err_at.exists(cyc)));
            if (|out_valid) begin
                check("onehot", 32'($onehot(out_valid)), 32'd1);
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else if (|(out_valid & out_ready)) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_ch", 32'(out_valid), 32'(6'b1 << e.ch));
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.l));
                end
            end
        end
    end

    // Drive one beat (caller is just after a posedge) and wait for acceptance.
    task automatic send_beat(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 0;
        if (!in_pkt) begin
            drop_m = (s >= NCH);
            if (!drop_m) lock_m = s;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sel      = s;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (drop_m && i == 0) check("drop_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) begin
                ok = 1;
                if (!in_pkt && drop_m) err_at[cyc + 1] = 1'b1;
                if (drop_m) begin
                    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                end else begin
                    sb_q.push_back('{ch: lock_m, d: d, l: l});
                end
                in_pkt = !l;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic go_idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        sel       = '0;
        out_ready = '1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err_sel", 32'(err_sel), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat packets to every channel, back-to-back.
        for (int c = 0; c < NCH; c++) send_beat(SW'(c), 8'hA0 + DW'(c), 1'b1);
        go_idle(3);

        // Packet lock: sel changes mid-packet are ignored.
        send_beat(3'd3, 8'h11, 1'b0);
        send_beat(3'd1, 8'h22, 1'b0);
        send_beat(3'd1, 8'h33, 1'b0);
        send_beat(3'd1, 8'h44, 1'b1);
        send_beat(3'd5, 8'h5A, 1'b1);
        go_idle(3);

        // Backpressure on channel 2.
        out_ready = 6'b111011;
        send_beat(3'd2, 8'h55, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h66;
        in_last  = 1'b1;
        sel      = 3'd0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'h55);
            check("bp_out_valid", 32'(out_valid), 32'b000100);
            @(posedge clk);
            #1;
        end
        out_ready = '1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        send_beat(3'd0, 8'h66, 1'b1);
        go_idle(3);

        // Illegal select: three-beat packet dropped, then normal routing.
        send_beat(3'd7, 8'h01, 1'b0);
        send_beat(3'd7, 8'h02, 1'b0);
        send_beat(3'd7, 8'h03, 1'b1);
        go_idle(1);
        check("drop_cnt_3", 32'(drop_cnt), 32'(exp_drop));
        check("drop_cnt_3_abs", 32'(drop_cnt), 32'd3);
        send_beat(3'd0, 8'h77, 1'b1);
        go_idle(3);

        // Reset mid-packet with a beat held.
        send_beat(3'd4, 8'hB1, 1'b0);
        send_beat(3'd4, 8'hB2, 1'b0);
        out_ready = '0;
        in_valid  = 1'b0;
        #1;
        check("pre_rst_held", 32'(out_valid), 32'b010000);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        sb_q.delete();
        err_at.delete();
        in_pkt   = 0;
        drop_m   = 0;
        exp_drop = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = '1;
        @(posedge clk);
        #1;
        send_beat(3'd1, 8'hC1, 1'b1);
        go_idle(3);

        // Saturation: 65534 dropped beats in one packet, then three more.
        send_beat(3'd6, 8'h00, 1'b0);
        for (int i = 0; i < 65532; i++) send_beat(3'd0, DW'(i), 1'b0);
        send_beat(3'd2, 8'hFF, 1'b1);
        go_idle(1);
        check("drop_cnt_fffe", 32'(drop_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) send_beat(3'd7, 8'hEE, 1'b1);
        go_idle(1);
        check("drop_cnt_sat", 32'(drop_cnt), 32'hFFFF);
        check("drop_cnt_model", 32'(drop_cnt), 32'(exp_drop));
        send_beat(3'd2, 8'h99, 1'b1);
        go_idle(3);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake and packet-locked routing. It is the sequential successor to the combinational 1-to-8 demux. It sits between a single stream producer and NUM_CH consumer channels. Each accepted beat is routed through a one-entry output register to exactly one channel. A select captured on the first beat of a packet holds until the packet's last beat, and illegal selects are dropped and counted.

## Interface
- NUM_CH, 8, number of output channels (2..64, need not be a power of two)
- DATA_W, 8, beat data width (≥1)
- SEL_W (localparam), $clog2(NUM_CH), select width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  DATA_W  beat payload
- in_last  input  1  final beat of packet
- sel  input  SEL_W  destination channel, sampled only on a packet's first beat
- out_valid  output  NUM_CH  one-hot per-channel valid (at most one bit set)
- out_ready  input  NUM_CH  per-channel ready
- out_data  output  DATA_W  shared payload bus, meaningful for the channel whose valid is set
- out_last  output  1  last flag of the held beat
- err_sel  output  1  one-cycle pulse when a packet's first beat carries sel ≥ NUM_CH
- drop_cnt  output  16  count of dropped beats, saturating at 16'hFFFF

## Operation
- FSM states:
  - IDLE: awaiting a packet's first beat.
  - FWD: mid-packet, routing to lock_ch.
  - DROP: mid-packet, discarding.
- IDLE, accepted beat with sel < NUM_CH: lock_ch ← sel; beat is loaded into the output register for channel sel. If !in_last, go to FWD.
- IDLE, in_valid with sel ≥ NUM_CH: beat is accepted and discarded; err_sel pulses; drop_cnt increments. If !in_last, go to DROP.
- FWD: every accepted beat routes to lock_ch, and sel is ignored. An accepted beat with in_last returns the FSM to IDLE.
- DROP: every in_valid beat is accepted and discarded, with drop_cnt incrementing per beat. The beat with in_last returns the FSM to IDLE. err_sel does not pulse again.
- Output register (one entry): full ⇔ |out_valid. The held beat drains when out_valid[ch] && out_ready[ch].
- in_ready is combinational:
  - IDLE with sel ≥ NUM_CH, or state DROP: 1.
  - Otherwise: !full || drain_this_cycle, where drain means the held beat's channel has ready high.
- Simultaneous drain and load: the new beat replaces the old in the same edge, and out_valid may move to a different channel with no bubble.
- A held beat's out_data, out_last and out_valid stay stable until drained. out_ready on non-selected channels is ignored.
- drop_cnt saturates: increments at 16'hFFFF have no effect.

## Timing
- Reset (async assert, sync deassert expected at the system level) forces:
  - out_valid=0, out_data=0, out_last=0, err_sel=0, drop_cnt=0
  - state=IDLE, lock_ch=0
- Reset asserted mid-packet or with a beat held discards both. The first post-reset beat is treated as a packet start.
- Latency: accept at edge k → out_valid set after edge k, visible in cycle k+1.
- Throughput: 1 beat/cycle while the destination channel holds out_ready=1.
- err_sel is high for exactly the cycle following the offending acceptance edge, since it is registered.
- in_ready has a combinational path from sel, out_ready and state. There is no path from in_valid to in_ready.

## Test plan
- NUM_CH=6, DATA_W=8, single-beat packets with sel=0..5, data=8'hA0+sel, last=1, all out_ready=1 → each beat appears one cycle later on out_valid=6'b1<<sel with matching data and out_last=1. No err_sel.
- 4-beat packet (data 11,22,33,44), sel=3 on beat 1 and sel changed to 1 on beats 2–4 → all four beats emerge on channel 3 back-to-back. The FSM is back in IDLE after beat 44.
- Backpressure: out_ready[2]=0 for 5 cycles with a beat held for channel 2 → in_ready=0 and out_data stable for 5 cycles. Releasing out_ready[2] drains the held beat and accepts the next beat in the same cycle.
- Illegal select: 3-beat packet with sel=7 (NUM_CH=6) → in_ready=1 throughout, no out_valid, err_sel pulses once, drop_cnt=3. The next packet with sel=0 routes normally.
- Saturation: drop_cnt preloaded to 16'hFFFE by 2 dropped beats short of full, then 3 more illegal beats → drop_cnt holds 16'hFFFF.
- Reset mid-packet: rst_n low after beat 2 of a sel=4 packet while a beat is held → out_valid=0 and drop_cnt=0 immediately. After release, a beat with sel=1 goes to channel 1.
